array_prod_feeder: RTL

Initiator/controller for the `array_prod` dot-product unit. It accepts a serial stream of (x, w) element pairs, packs them into the two flat `LAYER_BITWIDTH` vectors, and releases `array_prod` from reset to start a product. It then waits for `dataReady`, captures the result and offers it downstream on a valid/ready handshake. It replaces the hand-driven enable/reset sequencing, so the perceptron stage can run inside the RNN datapath without a testbench.

---
 rtl/rnn_fixed_pkg.sv | 29 ++
 rtl/array_prod_feeder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point definitions for the RNN datapath: format width,
// feeder state encoding and a constant-conversion helper for benches.
package rnn_fixed_pkg;

    localparam int QN_DEF = 6;
    localparam int QM_DEF = 11;

    // Total width of a signed fixed-point word: sign + integer + fraction.
    function automatic int calcBitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    localparam int BITWIDTH_DEF = calcBitwidth(QN_DEF, QM_DEF);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } feederState_t;

    // Rational constant num/den expressed in the default Q format (truncating).
    function automatic logic [BITWIDTH_DEF-1:0] to_fixed(input int num, input int den);
        int scaled;
        scaled = (num * (1 << QM_DEF)) / den;
        return scaled[BITWIDTH_DEF-1:0];
    endfunction

endpackage

// File: rtl/array_prod_feeder.sv
// Feeder/controller for array_prod: packs a serial (x, w) stream into the two
// flat operand vectors, releases array_prod from reset for one product, and
// presents the result (or a timeout marker) on a valid/ready handshake.
module array_prod_feeder
    import rnn_fixed_pkg::*;
#(
    parameter int HIDDEN_SZ      = 8,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int TIMEOUT        = 64,
    parameter int BITWIDTH       = calcBitwidth(QN, QM),
    parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
    parameter int ADDR_BITWIDTH  = $clog2(HIDDEN_SZ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITWIDTH-1:0]       in_x,
    input  logic [BITWIDTH-1:0]       in_w,
    output logic [LAYER_BITWIDTH-1:0] vecX,
    output logic [LAYER_BITWIDTH-1:0] vecW,
    output logic                      prodReset,
    input  logic                      prodReady,
    input  logic [BITWIDTH-1:0]       prodResult,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITWIDTH-1:0]       out_data,
    output logic                      out_error
);

    // One spare bit keeps the terminal count representable for any TIMEOUT.
    localparam int TIMER_BITWIDTH = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_BITWIDTH-1:0]  LAST_IDX  = ADDR_BITWIDTH'(HIDDEN_SZ - 1);
    localparam logic [TIMER_BITWIDTH-1:0] LAST_TICK = TIMER_BITWIDTH'(TIMEOUT - 1);

    feederState_t state;
    feederState_t stateNext;

    logic [ADDR_BITWIDTH-1:0]  idx;
    logic [TIMER_BITWIDTH-1:0] timer;
    logic                      accept;
    logic                      lastElem;
    logic                      timedOut;

    assign accept   = in_valid && in_ready;
    assign lastElem = (idx == LAST_IDX);
    assign timedOut = (timer == LAST_TICK);

    // State register; reset lands in LOAD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode: load N elements, settle one cycle, run, hold result.
    always_comb begin
        stateNext = state;
        case (state)
            LOAD: if (accept && lastElem)      stateNext = ARM;
            ARM:                               stateNext = RUN;
            RUN:  if (prodReady || timedOut)   stateNext = HOLD;
            HOLD: if (out_ready)               stateNext = LOAD;
            default:                           stateNext = LOAD;
        endcase
    end

    // Handshake and array_prod control decoded from the registered state.
    // in_ready is additionally masked by reset so nothing is accepted while
    // the block is held in reset.
    always_comb begin
        in_ready  = 1'b0;
        prodReset = 1'b1;
        out_valid = 1'b0;
        case (state)
            LOAD:    in_ready  = !reset;
            RUN:     prodReset = 1'b0;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Write each accepted pair into its slice and step the element index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vecX <= '0;
            vecW <= '0;
            idx  <= '0;
        end else if (accept) begin
            vecX[int'(idx)*BITWIDTH +: BITWIDTH] <= in_x;
            vecW[int'(idx)*BITWIDTH +: BITWIDTH] <= in_w;
            idx <= lastElem ? '0 : idx + ADDR_BITWIDTH'(1);
        end
    end

    // Count RUN cycles; cleared in the ARM cycle so RUN always starts at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ARM) begin
            timer <= '0;
        end else if (state == RUN) begin
            timer <= timer + TIMER_BITWIDTH'(1);
        end
    end

    // Capture the product, or flag a timeout; a simultaneous ready wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_error <= 1'b0;
        end else if (state == RUN) begin
            if (prodReady) begin
                out_data  <= prodResult;
                out_error <= 1'b0;
            end else if (timedOut) begin
                out_data  <= '0;
                out_error <= 1'b1;
            end
        end
    end

endmodule
